// File: rtl/halut_encoder_tree.sv
// Decision-tree encoder feeding the HALUT decoder: walks one balanced FP16
// threshold tree per codebook, one level per cycle, and emits (c, k) codes in codebook order.
module halut_encoder_tree #(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned TreeDepth     = $clog2(K),
  parameter int unsigned CAddrWidth    = $clog2(C),
  parameter int unsigned ThrAddrWidth  = $clog2(C*(K-1))
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [ThrAddrWidth-1:0]            waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  input  logic                               clear_i,
  input  logic [TreeDepth*DataTypeWidth-1:0] in_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic [CAddrWidth-1:0]              c_addr_o,
  output logic [TreeDepth-1:0]               k_addr_o,
  output logic                               valid_o
);

  localparam int unsigned NumThr = C * (K - 1);
  localparam int unsigned LvlW   = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;
  localparam int unsigned NodeW  = TreeDepth + 1;

  typedef enum logic {IDLE, TRAV} state_e;

  state_e                   state_q;
  logic [CAddrWidth-1:0]    c_cnt_q;
  logic [NodeW-1:0]         node_q;
  logic [LvlW-1:0]          level_q;
  logic [DataTypeWidth-1:0] thr_q [NumThr];
  logic [DataTypeWidth-1:0] in_q  [TreeDepth];

  logic [ThrAddrWidth-1:0]  thr_addr;
  logic [DataTypeWidth-1:0] thr_cur;
  logic [DataTypeWidth-1:0] x_cur;
  logic                     go_right;
  logic [NodeW-1:0]         node_nxt;
  logic [TreeDepth-1:0]     leaf;
  logic                     handshake;

  // Monotonic unsigned key for FP16 ordering; -0 folds onto +0 so they tie.
  function automatic logic [DataTypeWidth-1:0] order_key(input logic [DataTypeWidth-1:0] v);
    logic [DataTypeWidth-1:0] z;
    z = (v == {1'b1, {(DataTypeWidth-1){1'b0}}}) ? '0 : v;
    if (z[DataTypeWidth-1]) return ~z;
    return z | {1'b1, {(DataTypeWidth-1){1'b0}}};
  endfunction

  assign in_ready_o = (state_q == IDLE) && !clear_i;
  assign handshake  = in_valid_i && in_ready_o;

  always_comb begin
    thr_addr = ThrAddrWidth'(c_cnt_q) * ThrAddrWidth'(K - 1) + ThrAddrWidth'(node_q);
    thr_cur  = thr_q[thr_addr];
    x_cur    = in_q[level_q];
    go_right = order_key(x_cur) > order_key(thr_cur);
    node_nxt = {node_q[NodeW-2:0], 1'b0} + NodeW'(1) + NodeW'(go_right);
    leaf     = TreeDepth'(node_nxt - NodeW'(K - 1));
  end

  // Threshold store: writes land regardless of FSM state, visible next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumThr; i++) thr_q[i] <= '0;
    end else if (we_i && (32'(waddr_i) < NumThr)) begin
      thr_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) begin
      for (int l = 0; l < TreeDepth; l++) in_q[l] <= in_data_i[l*DataTypeWidth +: DataTypeWidth];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      c_cnt_q  <= '0;
      node_q   <= '0;
      level_q  <= '0;
      valid_o  <= 1'b0;
      c_addr_o <= '0;
      k_addr_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        state_q <= IDLE;
        c_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid_i) begin
              node_q  <= '0;
              level_q <= '0;
              state_q <= TRAV;
            end
          end
          TRAV: begin
            if (level_q == LvlW'(TreeDepth - 1)) begin
              k_addr_o <= leaf;
              c_addr_o <= c_cnt_q;
              valid_o  <= 1'b1;
              c_cnt_q  <= (c_cnt_q == CAddrWidth'(C - 1)) ? '0 : c_cnt_q + 1'b1;
              state_q  <= IDLE;
            end else begin
              node_q  <= node_nxt;
              level_q <= level_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_halut_encoder_tree.sv
// Directed bench for halut_encoder_tree with hand-computed leaf indices.
module tb_halut_encoder_tree;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [8:0]  waddr;
  logic [15:0] wdata;
  logic        we;
  logic        clear;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  c_addr;
  logic [3:0]  k_addr;
  logic        valid;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [15:0] P1   = 16'h3C00;
  localparam logic [15:0] M1   = 16'hBC00;
  localparam logic [15:0] TWO  = 16'h4000;
  localparam logic [15:0] FOUR = 16'h4400;
  localparam logic [15:0] HALF = 16'h3800;

  halut_encoder_tree dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .we_i      (we),
    .clear_i   (clear),
    .in_data_i (in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .c_addr_o  (c_addr),
    .k_addr_o  (k_addr),
    .valid_o   (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_thr(input int addr, input logic [15:0] d);
    we = 1'b1; waddr = 9'(addr); wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1 check("clear_ready_low", in_ready, 0);
    step();
    clear = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) check({tag, "_ready_timeout"}, in_ready, 1);
  endtask

  // Handshake, then expect exactly one valid pulse 4 cycles later.
  task automatic run_code(input string tag, input logic [63:0] d,
                          input logic [3:0] ek, input logic [4:0] ec);
    wait_ready(tag);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_early"}, valid, 0);
      step();
    end
    check({tag, "_valid"}, valid, 1);
    check({tag, "_k"}, k_addr, ek);
    check({tag, "_c"}, c_addr, ec);
    check({tag, "_ready"}, in_ready, 1);
    step();
    check({tag, "_pulse_end"}, valid, 0);
  endtask

  function automatic logic [3:0] b2b_k(input int c);
    case (c)
      3:       return 4'd11;
      4, 5:    return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  initial begin
    int hs_cnt, pulses, last_cyc;
    bit hs_pend;
    rst_ni = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clear = 1'b0;
    in_data = '0; in_valid = 1'b0;
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_valid", valid, 0);
    check("rst_c", c_addr, 0);
    check("rst_k", k_addr, 0);
    rst_ni = 1'b1;
    step();

    run_code("all_pos", {P1, P1, P1, P1}, 4'd15, 5'd0);
    run_code("all_neg", {M1, M1, M1, M1}, 4'd0, 5'd1);
    run_code("alt", {M1, P1, M1, P1}, 4'd10, 5'd2);
    write_thr(3*15+2, TWO);
    run_code("alt_n2", {M1, P1, M1, P1}, 4'd10, 5'd3);
    write_thr(4*15+0, TWO);
    run_code("alt_n0", {M1, P1, M1, P1}, 4'd2, 5'd4);
    run_code("neg_zero", {4{16'h8000}}, 4'd0, 5'd5);
    write_thr(6*15+0, HALF); write_thr(6*15+1, HALF);
    write_thr(6*15+3, HALF); write_thr(6*15+7, HALF);
    run_code("equal", {HALF, HALF, HALF, HALF}, 4'd0, 5'd6);

    // Clear while codebook 3 is at traversal level 2.
    do_clear();
    run_code("pre_clr0", {M1, M1, M1, M1}, 4'd0, 5'd0);
    run_code("pre_clr1", {M1, M1, M1, M1}, 4'd0, 5'd1);
    run_code("pre_clr2", {M1, M1, M1, M1}, 4'd0, 5'd2);
    wait_ready("clr");
    in_data = {P1, P1, P1, P1}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    do_clear();
    for (int i = 0; i < 6; i++) begin
      check("clr_no_valid", valid, 0);
      step();
    end
    run_code("post_clr", {P1, P1, P1, P1}, 4'd15, 5'd0);

    // 33 back-to-back inputs.
    do_clear();
    write_thr(5*15+0, FOUR);
    hs_cnt = 0; pulses = 0; last_cyc = -1;
    in_data = {P1, P1, P1, P1}; in_valid = 1'b1;
    for (int cyc = 0; cyc < 250 && pulses < 33; cyc++) begin
      hs_pend = in_ready && in_valid;
      step();
      if (hs_pend) begin
        hs_cnt++;
        if (hs_cnt == 33) in_valid = 1'b0;
      end
      if (valid) begin
        check("b2b_c", c_addr, 32'(pulses % 32));
        check("b2b_k", k_addr, b2b_k(pulses % 32));
        if (last_cyc >= 0) check("b2b_spacing", cyc - last_cyc, 5);
        last_cyc = cyc;
        pulses++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", pulses, 33);

    // Reset mid-traversal.
    wait_ready("rst_mid");
    in_data = {P1, P1, P1, P1}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_c", c_addr, 0);
    check("mid_rst_k", k_addr, 0);
    step();
    check("mid_rst_hold_valid", valid, 0);
    rst_ni = 1'b1;
    step();
    for (int c = 0; c < 7; c++) run_code("thr_cleared", {P1, P1, P1, P1}, 4'd15, 5'(c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
